// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Each grant runs SETUP/ACCESS, then returns a one-cycle response to its owner.
module apb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int APB_AW  = 32,
  parameter int APB_DW  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][APB_AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0][APB_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [APB_DW-1:0]              rsp_rdata,
  output logic                           rsp_err,
  output logic [APB_AW-1:0]              paddr,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [APB_DW-1:0]              pwdata,
  input  logic [APB_DW-1:0]              prdata,
  input  logic                           pready,
  input  logic                           pslverr
);
  localparam int PW     = $clog2(NUM_REQ);
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic              write;
    logic [APB_DW-1:0] wdata;
  } apb_req_t;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, own_q, own_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               psel_q, psel_d, penable_q, penable_d;
  apb_req_t           req_q, req_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               to_hit;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Scan downward so the last hit is the nearest valid requester at/after the pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(ptr_q, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // pready has priority over the timeout on the same edge.
  assign to_hit = (TIMEOUT != 0) && !pready && (cnt_q == CW'(TO_LIM));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    req_d       = req_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_d.addr  = req_addr[gnt_idx];
          req_d.write = req_write[gnt_idx];
          req_d.wdata = req_wdata[gnt_idx];
          own_d       = gnt_idx;
          ptr_d       = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d       = '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          rsp_valid_d[own_q] = 1'b1;
          rsp_err_d          = pslverr;
          rsp_rdata_d        = req_q.write ? '0 : prdata;
          state_d            = IDLE;
        end else if (to_hit) begin
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          rsp_valid_d[own_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_rdata_d        = '0;
          cnt_d              = cnt_q + 1'b1;
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = req_q.addr;
  assign pwrite    = req_q.write;
  assign pwdata    = req_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
